// File: rtl/shift_exec_stage.sv
// Two-stage MIPS shift execute unit: S1 holds decoded operands, S2 holds the result.
// Valid/ready handshakes on both sides; op_cnt saturates at 0xFFFF.
module shift_exec_stage #(
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       in_funct,
    input  logic [4:0]       in_shamt,
    input  logic [31:0]      in_rs,
    input  logic [31:0]      in_rt,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err,
    output logic [15:0]      op_cnt
);

    logic             s1_valid;
    logic [31:0]      s1_operand;
    logic [4:0]       s1_amt;
    logic             s1_left;
    logic             s1_arith;
    logic             s1_err;
    logic [TAG_W-1:0] s1_tag;

    logic       dec_left;
    logic       dec_arith;
    logic       dec_err;
    logic [4:0] dec_amt;

    logic        s2_load;
    logic        in_fire;
    logic [31:0] shifted;

    // S2 takes S1 when it is empty or being drained this cycle
    assign s2_load  = s1_valid && (!out_valid || out_ready);
    assign in_ready = !s1_valid || s2_load;
    assign in_fire  = in_valid && in_ready;

    always_comb begin
        dec_left  = 1'b0;
        dec_arith = 1'b0;
        dec_err   = 1'b0;
        dec_amt   = in_shamt;
        case (in_funct)
            6'b000000: dec_left = 1'b1;
            6'b000010: dec_left = 1'b0;
            6'b000011: dec_arith = 1'b1;
            6'b000100: begin
                dec_left = 1'b1;
                dec_amt  = in_rs[4:0];
            end
            6'b000110: dec_amt = in_rs[4:0];
            6'b000111: begin
                dec_arith = 1'b1;
                dec_amt   = in_rs[4:0];
            end
            default: dec_err = 1'b1;
        endcase
    end

    always_comb begin
        shifted = '0;
        if (s1_err)
            shifted = '0;
        else if (s1_left)
            shifted = s1_operand << s1_amt;
        else if (s1_arith)
            shifted = $unsigned($signed(s1_operand) >>> s1_amt);
        else
            shifted = s1_operand >> s1_amt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_operand <= '0;
            s1_amt     <= '0;
            s1_left    <= 1'b0;
            s1_arith   <= 1'b0;
            s1_err     <= 1'b0;
            s1_tag     <= '0;
        end else if (in_fire) begin
            s1_valid   <= 1'b1;
            s1_operand <= in_rt;
            s1_amt     <= dec_amt;
            s1_left    <= dec_left;
            s1_arith   <= dec_arith;
            s1_err     <= dec_err;
            s1_tag     <= in_tag;
        end else if (s2_load) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
            out_err    <= 1'b0;
        end else if (s2_load) begin
            out_valid  <= 1'b1;
            out_result <= shifted;
            out_tag    <= s1_tag;
            out_err    <= s1_err;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            op_cnt <= '0;
        else if (out_valid && out_ready && (op_cnt != '1))
            op_cnt <= op_cnt + 16'd1;
    end

endmodule

// File: tb/tb_shift_exec_stage.sv
// Directed self-checking bench for shift_exec_stage: decode, latency, streaming,
// stall/backpressure, mid-flight reset and op_cnt saturation.
module tb_shift_exec_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_funct;
    logic [4:0]  in_shamt;
    logic [31:0] in_rs;
    logic [31:0] in_rt;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_tag;
    logic        out_err;
    logic [15:0] op_cnt;

    int unsigned checks;
    int unsigned errors;
    logic [15:0] exp_cnt;

    shift_exec_stage #(.TAG_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_funct(in_funct), .in_shamt(in_shamt), .in_rs(in_rs), .in_rt(in_rt), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag), .out_err(out_err), .op_cnt(op_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_funct = '0; in_shamt = '0; in_rs = '0; in_rt = '0; in_tag = '0;
        #2;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (out_result !== 32'h0) begin errors++; $display("FAIL reset_out_result got %h want 0", out_result); end
        checks++; if (out_tag !== 5'd0) begin errors++; $display("FAIL reset_out_tag got %0d want 0", out_tag); end
        checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL reset_out_err got %b want 0", out_err); end
        checks++; if (op_cnt !== 16'd0) begin errors++; $display("FAIL reset_op_cnt got %0d want 0", op_cnt); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        step(); step();
        rst_n = 1'b1;
        exp_cnt = 16'd0;
        step();
    endtask

    task automatic test_shifts();
        logic [5:0]  t_funct [9] = '{6'b000000, 6'b000111, 6'b000110, 6'b000011, 6'b000010,
                                     6'b000100, 6'b000011, 6'b000111, 6'b100000};
        logic [4:0]  t_shamt [9] = '{5'd31, 5'd9, 5'd9, 5'd0, 5'd4, 5'd3, 5'd31, 5'd0, 5'd3};
        logic [31:0] t_rs    [9] = '{32'h0, 32'hFFFF_FFE4, 32'hFFFF_FFE4, 32'h0, 32'h0,
                                     32'h0000_0028, 32'h0, 32'h0000_001F, 32'h0};
        logic [31:0] t_rt    [9] = '{32'h0000_0001, 32'h8000_00F0, 32'h8000_00F0, 32'h8000_0000, 32'hF000_0000,
                                     32'h0000_00FF, 32'h7000_0000, 32'h8000_0000, 32'hFFFF_FFFF};
        logic [31:0] t_exp   [9] = '{32'h8000_0000, 32'hF800_000F, 32'h0800_000F, 32'h8000_0000, 32'h0F00_0000,
                                     32'h0000_FF00, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
        logic        t_err   [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 9; i++) begin
            in_funct = t_funct[i]; in_shamt = t_shamt[i]; in_rs = t_rs[i]; in_rt = t_rt[i];
            in_tag = 5'(i + 11); in_valid = 1'b1; out_ready = 1'b1;
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL shift%0d_in_ready got %b want 1", i, in_ready); end
            step();
            in_valid = 1'b0;
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL shift%0d_early_valid got %b want 0", i, out_valid); end
            step();
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL shift%0d_valid got %b want 1", i, out_valid); end
            checks++; if (out_result !== t_exp[i]) begin errors++; $display("FAIL shift%0d_result got %h want %h", i, out_result, t_exp[i]); end
            checks++; if (out_err !== t_err[i]) begin errors++; $display("FAIL shift%0d_err got %b want %b", i, out_err, t_err[i]); end
            checks++; if (out_tag !== 5'(i + 11)) begin errors++; $display("FAIL shift%0d_tag got %0d want %0d", i, out_tag, i + 11); end
            step();
            exp_cnt++;
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL shift%0d_drained got %b want 0", i, out_valid); end
            checks++; if (op_cnt !== exp_cnt) begin errors++; $display("FAIL shift%0d_op_cnt got %0d want %0d", i, op_cnt, exp_cnt); end
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1; in_funct = 6'b000000; in_shamt = 5'd1; in_rs = '0;
        for (int i = 0; i < 6; i++) begin
            in_valid = (i < 4);
            in_tag = 5'(i + 1);
            in_rt = 32'(i + 1);
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b%0d_in_ready got %b want 1", i, in_ready); end
            step();
            if (i >= 1 && i <= 4) begin
                checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b%0d_valid got %b want 1", i, out_valid); end
                checks++; if (out_tag !== 5'(i)) begin errors++; $display("FAIL b2b%0d_tag got %0d want %0d", i, out_tag, i); end
                checks++; if (out_result !== 32'(2 * i)) begin errors++; $display("FAIL b2b%0d_result got %h want %h", i, out_result, 2 * i); end
            end else begin
                checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b%0d_idle got %b want 0", i, out_valid); end
            end
        end
        in_valid = 1'b0;
        exp_cnt += 16'd4;
        checks++; if (op_cnt !== exp_cnt) begin errors++; $display("FAIL b2b_op_cnt got %0d want %0d", op_cnt, exp_cnt); end
    endtask

    task automatic test_stall();
        out_ready = 1'b0; in_funct = 6'b000010; in_shamt = 5'd4; in_rs = '0;
        in_valid = 1'b1; in_tag = 5'd5; in_rt = 32'h0000_0A00;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_ready_a got %b want 1", in_ready); end
        step();
        in_tag = 5'd6; in_rt = 32'h0000_0B00;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_ready_b got %b want 1", in_ready); end
        step();
        in_tag = 5'd7; in_rt = 32'h0000_0C00;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall%0d_in_ready got %b want 0", i, in_ready); end
            checks++; if (out_valid !== 1'b1 || out_tag !== 5'd5) begin errors++; $display("FAIL stall%0d_hold_tag got %b/%0d want 1/5", i, out_valid, out_tag); end
            checks++; if (out_result !== 32'h0000_00A0) begin errors++; $display("FAIL stall%0d_hold_result got %h want 000000a0", i, out_result); end
            step();
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready got %b want 1", in_ready); end
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_tag !== 5'd6 || out_result !== 32'h0000_00B0) begin
            errors++; $display("FAIL stall_drain_b got %b/%0d/%h want 1/6/000000b0", out_valid, out_tag, out_result); end
        step();
        checks++; if (out_valid !== 1'b1 || out_tag !== 5'd7 || out_result !== 32'h0000_00C0) begin
            errors++; $display("FAIL stall_drain_c got %b/%0d/%h want 1/7/000000c0", out_valid, out_tag, out_result); end
        step();
        exp_cnt += 16'd3;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_empty got %b want 0", out_valid); end
        checks++; if (op_cnt !== exp_cnt) begin errors++; $display("FAIL stall_op_cnt got %0d want %0d", op_cnt, exp_cnt); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0; in_funct = 6'b000000; in_shamt = 5'd0; in_rs = '0;
        in_valid = 1'b1; in_tag = 5'd8; in_rt = 32'h1111_1111;
        step();
        in_tag = 5'd9; in_rt = 32'h2222_2222;
        step();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        exp_cnt = 16'd0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid got %b want 0", out_valid); end
        checks++; if (op_cnt !== 16'd0) begin errors++; $display("FAIL rstmid_op_cnt got %0d want 0", op_cnt); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready got %b want 1", in_ready); end
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_flushed got %b want 0", out_valid); end
        in_valid = 1'b1; in_tag = 5'd10; in_rt = 32'h0000_0003; in_shamt = 5'd2;
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_early got %b want 0", out_valid); end
        step();
        checks++; if (out_valid !== 1'b1 || out_tag !== 5'd10 || out_result !== 32'h0000_000C) begin
            errors++; $display("FAIL rstmid_first got %b/%0d/%h want 1/10/0000000c", out_valid, out_tag, out_result); end
        step();
        exp_cnt++;
        checks++; if (op_cnt !== exp_cnt) begin errors++; $display("FAIL rstmid_op_cnt_after got %0d want %0d", op_cnt, exp_cnt); end
    endtask

    task automatic test_saturate();
        int unsigned budget;
        budget = 0;
        out_ready = 1'b1; in_funct = 6'b000000; in_shamt = 5'd1; in_rt = 32'h1; in_tag = 5'd1;
        in_valid = 1'b1;
        while (op_cnt !== 16'hFFFF && budget < 70000) begin
            step();
            budget++;
        end
        in_valid = 1'b0;
        checks++; if (op_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_reach got %h want ffff", op_cnt); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sat_pending got %b want 1", out_valid); end
        step();
        checks++; if (op_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got %h want ffff", op_cnt); end
        step(); step();
        checks++; if (op_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold2 got %h want ffff", op_cnt); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        exp_cnt = '0;
        test_reset();
        test_shifts();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
